// File: rtl/fft_stage_controller.sv
// Address and strobe sequencer for an in-place radix-2 DIT FFT on one shared butterfly.
// Issues one butterfly per RUN cycle. Writes follow the reads through a fixed-latency delay line.
module fft_stage_controller #(
    parameter int unsigned LOG2N  = 6,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned BF_LAT = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(LOG2N)-1:0]   stage,
    output logic                       rd_en,
    output logic [LOG2N-1:0]           rd_addr_a,
    output logic [LOG2N-1:0]           rd_addr_b,
    output logic [LOG2N-2:0]           tw_addr,
    output logic                       wr_en,
    output logic [LOG2N-1:0]           wr_addr_a,
    output logic [LOG2N-1:0]           wr_addr_b
);

    localparam int unsigned Sw  = $clog2(LOG2N);
    localparam int unsigned Bw  = LOG2N - 1;
    localparam int          Lat = int'(RD_LAT + BF_LAT);
    localparam int unsigned Pw  = 1 + 2 * LOG2N;

    localparam logic [Sw-1:0] SLast = Sw'(LOG2N - 1);
    localparam logic [2:0]    DLast = 3'(Lat - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e        state_q, state_d;
    logic [Sw-1:0] s_q, s_d;
    logic [Bw-1:0] b_q, b_d;
    logic [2:0]    drn_q, drn_d;
    logic          stage_end;

    logic [LOG2N-1:0] half, grp, addr_a, addr_b;
    logic [Bw-1:0]    pos, tw;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            s_q     <= '0;
            b_q     <= '0;
            drn_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            b_q     <= b_d;
            drn_q   <= drn_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        b_d       = b_q;
        drn_d     = drn_q;
        stage_end = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    s_d     = '0;
                    b_d     = '0;
                end
            end
            StRun: begin
                b_d = b_q + 1'b1;
                if (b_q == '1) begin
                    b_d = '0;
                    // With no pipeline delay the next stage can follow immediately.
                    if (Lat > 0) begin
                        state_d = StDrain;
                        drn_d   = '0;
                    end else begin
                        stage_end = 1'b1;
                    end
                end
            end
            StDrain: begin
                drn_d = drn_q + 1'b1;
                if (drn_q == DLast) begin
                    stage_end = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (stage_end) begin
            if (s_q == SLast) begin
                state_d = StDone;
            end else begin
                state_d = StRun;
                s_d     = s_q + 1'b1;
                b_d     = '0;
            end
        end
    end

    always_comb begin
        half   = LOG2N'(1) << s_q;
        grp    = {1'b0, b_q} >> s_q;
        pos    = b_q & Bw'(half - 1'b1);
        addr_a = ((grp << s_q) << 1) | {1'b0, pos};
        addr_b = addr_a + half;
        tw     = pos << (SLast - s_q);

        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        stage     = s_q;
        rd_en     = 1'b0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        tw_addr   = '0;
        if (state_q == StRun) begin
            rd_en     = 1'b1;
            rd_addr_a = addr_a;
            rd_addr_b = addr_b;
            tw_addr   = tw;
        end
    end

    logic [Pw-1:0] rd_word;
    assign rd_word = {rd_en, rd_addr_a, rd_addr_b};

    generate
        if (Lat == 0) begin : g_nolat
            assign {wr_en, wr_addr_a, wr_addr_b} = rd_word;
        end else begin : g_lat
            logic [Pw-1:0] pipe_q [Lat];
            logic [Pw-1:0] pipe_d [Lat];

            always_comb begin
                pipe_d[0] = rd_word;
                for (int i = 1; i < Lat; i++) begin
                    pipe_d[i] = pipe_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < Lat; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else begin
                    pipe_q <= pipe_d;
                end
            end

            assign {wr_en, wr_addr_a, wr_addr_b} = pipe_q[Lat-1];
        end
    endgenerate

endmodule

// File: tb/tb_fft_stage_controller.sv
// Scoreboard bench: a small (N=8) instance checked address by address, and a default (N=64)
// instance driving a RAM model and a butterfly model through an impulse transform.
module tb_fft_stage_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_s, start_s, busy_s, done_s, rd_en_s, wr_en_s;
    logic [1:0] stage_s, tw_s;
    logic [2:0] ra_s, rb_s, wa_s, wb_s;

    logic       rst_b, start_b, busy_b, done_b, rd_en_b, wr_en_b;
    logic [2:0] stage_b;
    logic [4:0] tw_b;
    logic [5:0] ra_b, rb_b, wa_b, wb_b;

    fft_stage_controller #(.LOG2N(3), .RD_LAT(1), .BF_LAT(0)) u_small (
        .clk(clk), .rst(rst_s), .start(start_s), .busy(busy_s), .done(done_s),
        .stage(stage_s), .rd_en(rd_en_s), .rd_addr_a(ra_s), .rd_addr_b(rb_s),
        .tw_addr(tw_s), .wr_en(wr_en_s), .wr_addr_a(wa_s), .wr_addr_b(wb_s)
    );

    fft_stage_controller #(.LOG2N(6), .RD_LAT(1), .BF_LAT(0)) u_big (
        .clk(clk), .rst(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
        .stage(stage_b), .rd_en(rd_en_b), .rd_addr_a(ra_b), .rd_addr_b(rb_b),
        .tw_addr(tw_b), .wr_en(wr_en_b), .wr_addr_a(wa_b), .wr_addr_b(wb_b)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int c;
        int a;
        int b;
        int t;
        int s;
    } op_t;

    op_t rdq[$];
    op_t wrq[$];
    int  doneq_s[$];
    int  doneq_b[$];

    // Hand-derived N=8 butterfly schedule, stages 0..2.
    int ta[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int tb[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int tt[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm, input int act);
        total++;
        bad++;
        $display("FAIL %s: got %0d expected none", nm, act);
    endtask

    task automatic chk_op(input string nm, input op_t e, input int c, input int a, input int b,
                          input int t, input int s);
        total++;
        if (c != e.c || a != e.a || b != e.b || (e.t >= 0 && t != e.t) ||
            (e.s >= 0 && s != e.s)) begin
            bad++;
            $display("FAIL %s: got cyc=%0d a=%0d b=%0d tw=%0d st=%0d expected cyc=%0d a=%0d b=%0d tw=%0d st=%0d",
                     nm, c, a, b, t, s, e.c, e.a, e.b, e.t, e.s);
        end
    endtask

    task automatic push_small(input int base);
        for (int i = 0; i < 12; i++) begin
            int rel;
            rel = (i / 4) * 5 + (i % 4);
            rdq.push_back('{base + rel, ta[i], tb[i], tt[i], i / 4});
            wrq.push_back('{base + rel + 1, ta[i], tb[i], -1, -1});
        end
        doneq_s.push_back(base + 15);
    endtask

    op_t er, ew;
    always @(negedge clk) begin
        if (rd_en_s) begin
            if (rdq.size() == 0) fail("rd_unexpected", cyc);
            else begin
                er = rdq.pop_front();
                chk_op("rd", er, cyc, int'(ra_s), int'(rb_s), int'(tw_s), int'(stage_s));
            end
        end
        if (wr_en_s) begin
            if (wrq.size() == 0) fail("wr_unexpected", cyc);
            else begin
                ew = wrq.pop_front();
                chk_op("wr", ew, cyc, int'(wa_s), int'(wb_s), 0, 0);
            end
        end
        if (done_s) begin
            if (doneq_s.size() == 0) fail("done_s_unexpected", cyc);
            else chk("done_s_cycle", cyc, doneq_s.pop_front());
            chk("busy_at_done", int'(busy_s), 1);
        end
        if (done_b) begin
            if (doneq_b.size() == 0) fail("done_b_unexpected", cyc);
            else chk("done_b_cycle", cyc, doneq_b.pop_front());
        end
    end

    // RAM model: 1-cycle registered read, butterfly output written on wr_en.
    logic        clr;
    logic [15:0] ram [64];
    logic [15:0] rda, rdb;
    int          rtw;
    logic [31:0] bfo;

    function automatic logic [31:0] bf(input logic [15:0] x, input logic [15:0] y, input int k);
        int  ar, ai, br, bi, o1r, o1i, o2r, o2i;
        real c, sn, tr, ti;
        ar  = int'($signed(x[15:8]));
        ai  = int'($signed(x[7:0]));
        br  = int'($signed(y[15:8]));
        bi  = int'($signed(y[7:0]));
        c   = $cos(6.283185307179586 * k / 64.0);
        sn  = $sin(6.283185307179586 * k / 64.0);
        tr  = br * c + bi * sn;
        ti  = bi * c - br * sn;
        o1r = $rtoi($floor((ar + tr) / 2.0));
        o1i = $rtoi($floor((ai + ti) / 2.0));
        o2r = $rtoi($floor((ar - tr) / 2.0));
        o2i = $rtoi($floor((ai - ti) / 2.0));
        return {o1r[7:0], o1i[7:0], o2r[7:0], o2i[7:0]};
    endfunction

    assign bfo = bf(rda, rdb, rtw);

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 64; i++) ram[i] <= (i == 0) ? 16'h4000 : 16'h0000;
        end else begin
            if (wr_en_b) begin
                ram[wa_b] <= bfo[31:16];
                ram[wb_b] <= bfo[15:0];
            end
            if (rd_en_b) begin
                rda <= ram[ra_b];
                rdb <= ram[rb_b];
                rtw <= int'(tw_b);
            end
        end
    end

    task automatic wait_done(input bit big, input int lim);
        int n;
        n = 0;
        while (!(big ? done_b : done_s) && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (!(big ? done_b : done_s)) fail(big ? "done_b_timeout" : "done_s_timeout", n);
    endtask

    task automatic check_bins();
        for (int i = 0; i < 64; i++) chk($sformatf("bin%0d", i), int'(ram[i]), 16'h0100);
    endtask

    task automatic run_big();
        clr = 1'b1;
        @(negedge clk);
        clr     = 1'b0;
        start_b = 1'b1;
        doneq_b.push_back(cyc + 1 + 198);
        @(negedge clk);
        start_b = 1'b0;
        wait_done(1'b1, 300);
        @(negedge clk);
        check_bins();
    endtask

    initial begin
        int base;
        rst_s   = 1'b1;
        rst_b   = 1'b1;
        start_s = 1'b0;
        start_b = 1'b0;
        clr     = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_small", int'({busy_s, done_s, stage_s, rd_en_s, ra_s, rb_s, tw_s, wr_en_s,
                                 wa_s, wb_s}), 0);
        chk("reset_big_ctl", int'({busy_b, done_b, rd_en_b, wr_en_b, stage_b, tw_b}), 0);
        chk("reset_big_addr", int'(ra_b | rb_b | wa_b | wb_b), 0);

        start_s = 1'b1;
        @(negedge clk);
        chk("rst_beats_start", int'(busy_s), 0);
        start_s = 1'b0;
        rst_s   = 1'b0;
        rst_b   = 1'b0;
        clr     = 1'b0;
        @(negedge clk);

        // Single transform, plus a start pulse while busy that must be ignored.
        start_s = 1'b1;
        base    = cyc + 1;
        push_small(base);
        @(negedge clk);
        start_s = 1'b0;
        repeat (5) @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        wait_done(1'b0, 40);
        @(negedge clk);
        chk("idle_after_done", int'(busy_s), 0);
        repeat (4) @(negedge clk);

        // Held start: back-to-back transforms with one IDLE cycle between them.
        start_s = 1'b1;
        base    = cyc + 1;
        push_small(base);
        push_small(base + 17);
        while (cyc < base + 20) @(negedge clk);
        start_s = 1'b0;
        repeat (30) @(negedge clk);
        chk("idle_after_held", int'(busy_s), 0);

        run_big();

        // Abort at cycle 40 of a transform.
        clr = 1'b1;
        @(negedge clk);
        clr     = 1'b0;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        repeat (40) @(negedge clk);
        chk("rd_en_before_abort", int'(rd_en_b), 1);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        chk("abort_idle", int'({busy_b, rd_en_b, wr_en_b}), 0);
        repeat (250) @(negedge clk);
        chk("abort_stays_idle", int'(busy_b), 0);

        run_big();

        chk("rdq_left", rdq.size(), 0);
        chk("wrq_left", wrq.size(), 0);
        chk("doneq_s_left", doneq_s.size(), 0);
        chk("doneq_b_left", doneq_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
